firmware_loader: RTL and testbench
==================================

// Module: firmware_loader
// PURPOSE
//  Synthesizable boot path: receives a firmware image as a byte stream, assembles
//  little-endian 32-bit words, writes them into processor memory from word address 0,
//  then releases the processor from reset. Sits between the host link and the
//  processor's memory write port. Consumes processor trap: halts the core and re-arms for a new image.
// PARAMETERS
//  ADDR_W     12    memory word-address width
//  MAX_WORDS  4096  largest accepted image in words; must be <= 2**ADDR_W
// PORTS
//  clk          in   1       clock; all logic on posedge
//  reset        in   1       synchronous, active-high reset
//  in_valid     in   1       byte stream valid
//  in_data      in   8       byte stream data
//  in_ready     out  1       byte accepted when in_valid && in_ready
//  mem_we       out  1       one-cycle memory write strobe
//  mem_addr     out  ADDR_W  word address of write
//  mem_wdata    out  32      write data
//  cpu_reset_n  out  1       processor reset, active-low; 0 while loading
//  trap         in   1       processor trap/halt request
//  done         out  1       image loaded, processor running
//  error        out  1       image rejected; sticky until reset
// BEHAVIOUR
//  Reset values: in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_reset_n=0, done=0, error=0;
//   state=S_LEN, byte/word counters=0. in_ready rises the cycle after reset deasserts.
//  Image format: 4-byte LE word count N, then N words of 4 bytes each, LE (first byte -> [7:0]).
//  States:
//   S_LEN : in_ready=1; collect 4 bytes into N. After 4th: N==0 -> S_RUN; N>MAX_WORDS -> S_ERR; else S_DATA.
//   S_DATA: in_ready=1; every 4th accepted byte completes a word; next cycle mem_we=1,
//    mem_addr=word index, mem_wdata=word. Stream may continue at 1 byte/cycle (no stall).
//    After word N-1 is written -> S_RUN (or S_CSUM with checksum option).
//   S_RUN : in_ready=0; cpu_reset_n=1, done=1. First S_RUN cycle is the cycle after the final mem_we.
//    trap==1 -> cpu_reset_n=0, done=0 next cycle, counters cleared, -> S_LEN (reload).
//   S_ERR : in_ready=0, error=1, cpu_reset_n=0; exits only on reset.
//  Gaps in in_valid allowed anywhere; partial words are held, never written.
//  trap ignored outside S_RUN. Reset mid-image: state discarded, already-written words left in memory.
//  mem_addr never exceeds N-1; word counter ADDR_W+1 bits to avoid wrap at N=2**ADDR_W.
// CONFIGURATION
//  LOADER_CHECKSUM_EN defined: after data, state S_CSUM collects 4 LE bytes; compare to
//   running sum of all N data words mod 2**32 (N==0 -> sum 0, S_LEN goes to S_CSUM).
//   Match -> S_RUN; mismatch -> S_ERR (memory writes already done remain).
//  Not defined: S_CSUM absent; last data word leads directly to S_RUN; no adder logic.
// STRUCTURE
//  loader_pkg: state enum {S_LEN,S_DATA,S_CSUM,S_RUN,S_ERR}, BYTES_PER_WORD=4, HDR_BYTES=4.
//  Sub-module byte_assembler: shifts bytes into a 32-bit LE word, 2-bit byte count,
//   one-cycle word_valid pulse; reused for length, data and checksum fields.
// TESTING
//  1 N=3, words 0x11223344,0xAABBCCDD,0x00000001 back-to-back -> 3 mem_we at addr 0,1,2 with
//    those values; cpu_reset_n=1 and done=1 the cycle after the 3rd write.
//  2 Same image with random in_valid gaps -> identical writes, no write on partial word.
//  3 N=MAX_WORDS+1 -> error=1, in_ready=0, no mem_we, cpu_reset_n stays 0 until reset.
//  4 N=0 -> no writes, S_RUN right after the 4th header byte (checksum 0 required when enabled).
//  5 Running, pulse trap -> cpu_reset_n=0 next cycle, in_ready=1; second image N=1 0xDEADBEEF
//    -> write addr 0, restart.
//  6 LOADER_CHECKSUM_EN: N=2 words 1,2, checksum 3 -> run; checksum 4 -> error=1.
//    Reset asserted mid-data -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/loader_pkg.sv
// rtl/loader_pkg.sv - shared state encodings, field sizes and LE byte-shift helper
package loader_pkg;

  typedef logic [2:0] state_t;

  localparam state_t S_LEN  = 3'd0;
  localparam state_t S_DATA = 3'd1;
  localparam state_t S_CSUM = 3'd2;
  localparam state_t S_RUN  = 3'd3;
  localparam state_t S_ERR  = 3'd4;

  localparam int BYTES_PER_WORD = 4;
  localparam int HDR_BYTES      = 4;

  // New byte enters at the top so the first byte of a word ends up in [7:0].
  function automatic logic [31:0] le_shift(input logic [31:0] word, input logic [7:0] data);
    return {data, word[31:8]};
  endfunction

endpackage

// File: rtl/byte_assembler.sv
// rtl/byte_assembler.sv - packs accepted bytes into 32-bit LE words with a one-cycle word_valid pulse
module byte_assembler
  import loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        i_clear,
  input  logic        i_valid,
  input  logic [7:0]  i_data,
  output logic [31:0] o_word,
  output logic        o_word_valid,
  output logic        o_last
);

  logic [31:0] r_shift;
  logic [1:0]  r_cnt;
  logic [31:0] r_word;
  logic        r_word_valid;
  logic [31:0] w_shift_next;

  assign w_shift_next = le_shift(r_shift, i_data);
  assign o_last       = i_valid && (r_cnt == 2'(BYTES_PER_WORD - 1));
  assign o_word       = r_word;
  assign o_word_valid = r_word_valid;

  always_ff @(posedge clk) begin
    if (reset || i_clear) begin
      r_shift      <= '0;
      r_cnt        <= '0;
      r_word       <= '0;
      r_word_valid <= 1'b0;
    end else begin
      r_word_valid <= 1'b0;
      if (i_valid) begin
        r_shift <= w_shift_next;
        r_cnt   <= r_cnt + 2'd1;
        if (o_last) begin
          r_word       <= w_shift_next;
          r_word_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/firmware_loader.sv
// rtl/firmware_loader.sv - byte-stream image loader into processor memory; LOADER_CHECKSUM_EN adds a trailing checksum check
module firmware_loader
  import loader_pkg::*;
#(
  parameter int ADDR_W    = 12,
  parameter int MAX_WORDS = 4096
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_reset_n,
  input  logic              trap,
  output logic              done,
  output logic              error
);

  localparam int          CW      = ADDR_W + 1;
  localparam logic [31:0] MAX_W32 = 32'(MAX_WORDS);

  state_t        r_state;
  logic [CW-1:0] r_len;
  logic [CW-1:0] r_cnt;
  logic          r_rdy;
  logic          r_stop;

  logic          w_accept;
  logic          w_reload;
  logic [31:0]   w_word;
  logic          w_word_valid;
  logic          w_last;
  logic          w_last_idx;
  logic          w_end_input;

  assign w_accept   = in_valid && r_rdy;
  assign w_reload   = (r_state == S_RUN) && trap;
  assign w_last_idx = (r_cnt == (r_len - CW'(1)));

  byte_assembler u_asm (
    .clk          (clk),
    .reset        (reset),
    .i_clear      (w_reload),
    .i_valid      (w_accept),
    .i_data       (in_data),
    .o_word       (w_word),
    .o_word_valid (w_word_valid),
    .o_last       (w_last)
  );

  // The byte that closes the image drops in_ready at once, before the FSM reacts to it.
  always_comb begin
    w_end_input = 1'b0;
    if (w_last) begin
      case (r_state)
`ifdef LOADER_CHECKSUM_EN
        S_LEN:  w_end_input = (le_shift(u_asm.r_shift, in_data) > MAX_W32);
        S_CSUM: w_end_input = 1'b1;
`else
        S_LEN:  w_end_input = (le_shift(u_asm.r_shift, in_data) > MAX_W32) ||
                              (le_shift(u_asm.r_shift, in_data) == 32'd0);
        S_DATA: w_end_input = w_last_idx;
`endif
        default: w_end_input = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rdy  <= 1'b0;
      r_stop <= 1'b0;
    end else if (w_reload) begin
      r_rdy  <= 1'b1;
      r_stop <= 1'b0;
    end else if ((r_state == S_RUN) || (r_state == S_ERR)) begin
      r_rdy <= 1'b0;
    end else if (w_accept && w_end_input) begin
      r_rdy  <= 1'b0;
      r_stop <= 1'b1;
    end else begin
      r_rdy <= !r_stop;
    end
  end

`ifdef LOADER_CHECKSUM_EN
  logic [31:0] r_sum;

  always_ff @(posedge clk) begin
    if (reset || w_reload) begin
      r_sum <= '0;
    end else if (w_word_valid && (r_state == S_DATA)) begin
      r_sum <= r_sum + w_word;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_LEN;
      r_len   <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_LEN: begin
          if (w_word_valid) begin
            if (w_word == 32'd0) begin
`ifdef LOADER_CHECKSUM_EN
              r_state <= S_CSUM;
`else
              r_state <= S_RUN;
`endif
            end else if (w_word > MAX_W32) begin
              r_state <= S_ERR;
            end else begin
              r_len   <= w_word[CW-1:0];
              r_state <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (w_word_valid) begin
            r_cnt <= r_cnt + CW'(1);
            if (w_last_idx) begin
`ifdef LOADER_CHECKSUM_EN
              r_state <= S_CSUM;
`else
              r_state <= S_RUN;
`endif
            end
          end
        end
`ifdef LOADER_CHECKSUM_EN
        S_CSUM: begin
          if (w_word_valid) begin
            r_state <= (w_word == r_sum) ? S_RUN : S_ERR;
          end
        end
`endif
        S_RUN: begin
          if (trap) begin
            r_state <= S_LEN;
            r_len   <= '0;
            r_cnt   <= '0;
          end
        end
        S_ERR:   r_state <= S_ERR;
        default: r_state <= S_ERR;
      endcase
    end
  end

  assign in_ready    = r_rdy;
  assign mem_we      = w_word_valid && (r_state == S_DATA);
  assign mem_addr    = r_cnt[ADDR_W-1:0];
  assign mem_wdata   = w_word;
  assign cpu_reset_n = (r_state == S_RUN);
  assign done        = (r_state == S_RUN);
  assign error       = (r_state == S_ERR);

endmodule

// File: tb/tb_firmware_loader.sv
// tb/tb_firmware_loader.sv - directed bench with write scoreboard for firmware_loader
module tb_firmware_loader;

  localparam int AW = 4;
  localparam int MW = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic [7:0]    in_data = 8'h00;
  logic          in_ready;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          cpu_reset_n;
  logic          trap = 1'b0;
  logic          done;
  logic          error;

  int n_vec = 0;
  int n_err = 0;
  logic [AW+31:0] sb[$];

  firmware_loader #(.ADDR_W(AW), .MAX_WORDS(MW)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .cpu_reset_n (cpu_reset_n),
    .trap        (trap),
    .done        (done),
    .error       (error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_write", {mem_addr, mem_wdata}, 64'hdead);
      end else begin
        logic [AW+31:0] e;
        e = sb.pop_front();
        chk("write_addr", 64'(mem_addr), 64'(e[AW+31:32]));
        chk("write_data", 64'(mem_wdata), 64'(e[31:0]));
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    int tries;
    repeat (gap) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    tries    = 0;
    while (!in_ready && tries < 50) begin
      @(negedge clk);
      tries++;
    end
    if (tries >= 50) chk("ready_timeout", 64'(in_ready), 64'd1);
  endtask

  task automatic send_word(input logic [31:0] w, input bit gaps);
    for (int k = 0; k < 4; k++) begin
      logic [31:0] t;
      t = w >> (8 * k);
      send_byte(t[7:0], gaps ? int'($urandom_range(0, 3)) : 0);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    in_valid = 1'b0;
    reset    = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  // Sends header, data words and (when enabled) checksum, then checks the run handoff timing.
  task automatic load_image(input logic [31:0] w[$], input bit gaps, input string tag);
    logic [31:0] sum;
    sum = 32'd0;
    send_word(32'(w.size()), gaps);
    for (int i = 0; i < w.size(); i++) begin
      sb.push_back({AW'(i), w[i]});
      sum = sum + w[i];
      send_word(w[i], gaps);
    end
`ifdef LOADER_CHECKSUM_EN
    send_word(sum, gaps);
`endif
    @(negedge clk);
    in_valid = 1'b0;
    chk({tag, "_done_early"}, 64'(done), 64'd0);
    @(negedge clk);
    chk({tag, "_run"}, 64'({cpu_reset_n, done, in_ready, error}), 64'b1100);
    chk({tag, "_sb_empty"}, 64'(sb.size()), 64'd0);
  endtask

  initial begin
    logic [31:0] img[$];

    // reset values
    @(negedge clk);
    @(negedge clk);
    chk("reset_outputs", 64'({in_ready, mem_we, mem_addr, mem_wdata, cpu_reset_n, done, error}), 64'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", 64'(in_ready), 64'd1);

    // three words back-to-back
    img = '{32'h11223344, 32'hAABBCCDD, 32'h00000001};
    load_image(img, 1'b0, "img3");

    // same image with random gaps
    do_reset();
    load_image(img, 1'b1, "img3_gaps");

    // trap reloads, second image
    @(negedge clk);
    trap = 1'b1;
    @(negedge clk);
    trap = 1'b0;
    chk("trap_halt", 64'({cpu_reset_n, done, in_ready}), 64'b001);
    img = '{32'hDEADBEEF};
    load_image(img, 1'b0, "reload");

    // empty image
    do_reset();
    img = '{};
    load_image(img, 1'b0, "empty");

    // largest accepted image exercises the widened word counter
    do_reset();
    img = '{};
    for (int i = 0; i < MW; i++) img.push_back($urandom);
    load_image(img, 1'b1, "max_img");

    // oversize header is rejected
    do_reset();
    send_word(32'(MW + 1), 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    chk("oversize_err", 64'({error, in_ready, cpu_reset_n, done}), 64'b1000);
    trap = 1'b1;
    repeat (4) @(negedge clk);
    trap = 1'b0;
    chk("err_sticky", 64'({error, in_ready, cpu_reset_n}), 64'b100);
    chk("err_no_write", 64'(sb.size()), 64'd0);

`ifdef LOADER_CHECKSUM_EN
    // checksum mismatch: writes happen, then error
    do_reset();
    send_word(32'd2, 1'b0);
    sb.push_back({AW'(0), 32'd1});
    send_word(32'd1, 1'b0);
    sb.push_back({AW'(1), 32'd2});
    send_word(32'd2, 1'b0);
    send_word(32'd4, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    chk("csum_bad", 64'({error, cpu_reset_n, done, in_ready}), 64'b1000);
    chk("csum_bad_writes", 64'(sb.size()), 64'd0);
`endif

    // reset mid-data: earlier word written, partial word dropped
    do_reset();
    send_word(32'd3, 1'b0);
    sb.push_back({AW'(0), 32'hCAFEF00D});
    send_word(32'hCAFEF00D, 1'b0);
    send_byte(8'h55, 0);
    send_byte(8'h66, 0);
    @(negedge clk);
    in_valid = 1'b0;
    reset    = 1'b1;
    @(negedge clk);
    chk("midreset_outputs", 64'({in_ready, mem_we, mem_addr, mem_wdata, cpu_reset_n, done, error}), 64'd0);
    chk("midreset_sb", 64'(sb.size()), 64'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("midreset_ready", 64'(in_ready), 64'd1);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
